// File: rtl/genius_pkg.sv
// Shared constants, state encoding and symbol helpers for the Genius sequence generator.
// The no-repeat option (GENIUS_NO_REPEAT_EN) is consumed by genius_seq_gen.
package genius_pkg;

  localparam int SYM_W   = 4;
  localparam int MAX_LEN = 16;
  localparam int WORD_W  = SYM_W * MAX_LEN;
  localparam int LFSR_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam logic [SYM_W-1:0] C_GREEN  = 4'b0001;
  localparam logic [SYM_W-1:0] C_RED    = 4'b0010;
  localparam logic [SYM_W-1:0] C_YELLOW = 4'b0100;
  localparam logic [SYM_W-1:0] C_BLUE   = 4'b1000;

  // Feedback taps for x^16+x^14+x^13+x^11+1 (bit i = x^(i+1)).
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [SYM_W-1:0] decode_sym(input logic [1:0] sel);
    return C_GREEN << sel;
  endfunction

  function automatic logic [SYM_W-1:0] rotl_sym(input logic [SYM_W-1:0] s);
    return {s[SYM_W-2:0], s[SYM_W-1]};
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running Fibonacci LFSR; shifts on every clock, never leaves the non-zero state space.
module genius_lfsr
  import genius_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              R_n,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/genius_seq_gen.sv
// Builds the Genius colour sequence one one-hot symbol per round and strobes it into the game register.
// Optional GENIUS_NO_REPEAT_EN: rotate a symbol that would repeat its predecessor.
module genius_seq_gen
  import genius_pkg::*;
#(
  parameter int                WORD_W  = genius_pkg::WORD_W,
  parameter int                SYM_W   = genius_pkg::SYM_W,
  parameter int                MAX_LEN = genius_pkg::MAX_LEN,
  parameter int                LFSR_W  = genius_pkg::LFSR_W,
  parameter logic [LFSR_W-1:0] SEED    = genius_pkg::DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              R_n,
  input  logic              start,
  input  logic              next,
  output logic [WORD_W-1:0] data,
  output logic              E,
  output logic [4:0]        len,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

  localparam int LEN_W = 5;

  logic [LFSR_W-1:0] lfsr_val;
  logic              unused_lfsr_hi;

  genius_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk (clk),
    .R_n (R_n),
    .q   (lfsr_val)
  );

  assign unused_lfsr_hi = ^lfsr_val[LFSR_W-1:2];

  state_e            state_q, state_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic [SYM_W-1:0]  sym;
  logic              full_w;

  assign full_w = (len_q == LEN_W'(MAX_LEN));

`ifdef GENIUS_NO_REPEAT_EN
  logic [SYM_W-1:0] last_q, last_d;

  // len_q == 0 marks the first symbol after start, which is never rotated.
  always_comb begin
    sym = SYM_W'(decode_sym(lfsr_val[1:0]));
    if ((len_q != '0) && (sym == last_q)) sym = {sym[SYM_W-2:0], sym[SYM_W-1]};
  end

  always_comb begin
    last_d = last_q;
    if (state_q == GEN && !start) last_d = sym;
  end

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) last_q <= '0;
    else      last_q <= last_d;
  end
`else
  always_comb begin
    sym = SYM_W'(decode_sym(lfsr_val[1:0]));
  end
`endif

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // start is honoured in every state and always (re)enters GEN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start || (next && !full_w)) state_d = GEN;
      GEN:     state_d = start ? GEN : LOAD;
      LOAD:    state_d = start ? GEN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    ovf_d  = ovf_q;
    if (start) begin
      data_d = '0;
      len_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (next && full_w) ovf_d = 1'b1;
        GEN: begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (len_q == LEN_W'(i)) data_d[WORD_W-1-SYM_W*i -: SYM_W] = sym;
          end
          if (!full_w) len_d = len_q + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // A start arriving during LOAD aborts the symbol, so its strobe is suppressed.
  always_comb begin
    E    = (state_q == LOAD) && !start;
    busy = (state_q != IDLE);
  end

  assign data     = data_q;
  assign len      = len_q;
  assign full     = full_w;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_genius_seq_gen.sv
// Directed bench for genius_seq_gen with an independent LFSR/sequence reference model.
module tb_genius_seq_gen;

  logic        clk = 1'b0;
  logic        R_n = 1'b1;
  logic        start = 1'b0;
  logic        next = 1'b0;
  logic [63:0] data;
  logic        E, busy, full, overflow;
  logic [4:0]  len;

  always #5 clk = ~clk;

  genius_seq_gen dut (
    .clk      (clk),
    .R_n      (R_n),
    .start    (start),
    .next     (next),
    .data     (data),
    .E        (E),
    .len      (len),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11+1, left-shifting Fibonacci form.
  logic [15:0] m;
  always @(posedge clk or negedge R_n) begin
    if (!R_n) m <= 16'hACE1;
    else      m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  int          errors = 0;
  int          checks = 0;
  int          e_count = 0;
  logic [63:0] exp_data = '0;
  int          exp_len = 0;
  logic        exp_ovf = 1'b0;
  logic [3:0]  prev_sym = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One request: start/next sampled at the first edge, GEN in between, LOAD after the second.
  task automatic req(input logic s, input logic n, input logic n_in_gen);
    logic [3:0] s_exp;
    @(negedge clk);
    start = s;
    next  = n;
    @(posedge clk); #1;
    start = 1'b0;
    next  = n_in_gen;
    chk("busy_gen", {63'd0, busy}, 64'd1);
    chk("e_gen", {63'd0, E}, 64'd0);
    if (s) begin
      exp_data = '0;
      exp_len  = 0;
      exp_ovf  = 1'b0;
    end
    s_exp = 4'b0001 << m[1:0];
`ifdef GENIUS_NO_REPEAT_EN
    if (exp_len != 0 && s_exp == prev_sym) s_exp = {s_exp[2:0], s_exp[3]};
`endif
    exp_data[63-4*exp_len -: 4] = s_exp;
    exp_len++;
    prev_sym = s_exp;
    @(posedge clk); #1;
    next = 1'b0;
    if (E === 1'b1) e_count++;
    chk("e_load", {63'd0, E}, 64'd1);
    chk("data_load", data, exp_data);
    chk("len_load", {59'd0, len}, 64'(exp_len));
    chk("full_load", {63'd0, full}, {63'd0, exp_len == 16});
    chk("ovf_load", {63'd0, overflow}, {63'd0, exp_ovf});
    @(posedge clk); #1;
    if (E === 1'b1) e_count++;
    chk("e_after", {63'd0, E}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    // Reset held for three cycles.
    #1 R_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 64'd0);
    chk("rst_e", {63'd0, E}, 64'd0);
    chk("rst_len", {59'd0, len}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    R_n = 1'b1;
    #1;
    chk("lfsr_seed", {48'd0, dut.lfsr_val}, 64'h0000_0000_0000_ACE1);
    @(posedge clk); #1;
    chk("lfsr_step1", {48'd0, dut.lfsr_val}, 64'h0000_0000_0000_59C3);
    chk("lfsr_model", {48'd0, dut.lfsr_val}, {48'd0, m});

    // First symbol after start.
    req(1'b1, 1'b0, 1'b0);
    chk("sym0_onehot", {63'd0, $onehot(data[63:60])}, 64'd1);
    chk("sym0_low_zero", {4'd0, data[59:0]}, 64'd0);
    chk("lfsr_model2", {48'd0, dut.lfsr_val}, {48'd0, m});

    // Fill to sixteen symbols, one request every four cycles.
    e_count = 0;
    for (int k = 0; k < 15; k++) begin
      req(1'b0, 1'b1, 1'b0);
      @(posedge clk);
    end
    chk("fill_e_count", 64'(e_count), 64'd15);
    chk("fill_len", {59'd0, len}, 64'd16);
    chk("fill_full", {63'd0, full}, 64'd1);
    for (int k = 0; k < 16; k++) begin
      chk("fill_onehot", {63'd0, $onehot(data[63-4*k -: 4])}, 64'd1);
    end

    // next while full: no round, overflow sets and sticks.
    @(negedge clk);
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    chk("ovf_busy", {63'd0, busy}, 64'd0);
    chk("ovf_set", {63'd0, overflow}, 64'd1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("ovf_no_e", {63'd0, E}, 64'd0);
      chk("ovf_data", data, exp_data);
    end
    exp_ovf = 1'b1;
    req(1'b1, 1'b0, 1'b0);
    chk("ovf_cleared", {63'd0, overflow}, 64'd0);
    chk("restart_len", {59'd0, len}, 64'd1);

    // start and next together: start wins, single strobe.
    e_count = 0;
    req(1'b1, 1'b1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      if (E === 1'b1) e_count++;
    end
    chk("both_e_count", 64'(e_count), 64'd1);
    chk("both_len", {59'd0, len}, 64'd1);

    // next during GEN is dropped.
    e_count = 0;
    req(1'b0, 1'b1, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      if (E === 1'b1) e_count++;
    end
    chk("gen_next_e_count", 64'(e_count), 64'd1);
    chk("gen_next_len", {59'd0, len}, 64'd2);

    // Reset asserted during LOAD.
    @(negedge clk);
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    @(posedge clk); #1;
    chk("load_e_before", {63'd0, E}, 64'd1);
    R_n = 1'b0;
    #1;
    chk("arst_e", {63'd0, E}, 64'd0);
    chk("arst_data", data, 64'd0);
    chk("arst_len", {59'd0, len}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    R_n = 1'b1;
    exp_data = '0;
    exp_len  = 0;
    exp_ovf  = 1'b0;

`ifdef GENIUS_NO_REPEAT_EN
    // Many rounds with random spacing; adjacent nibbles must differ.
    for (int r = 0; r < 1000; r++) begin
      if (exp_len == 0 || exp_len == 16) req(1'b1, 1'b0, 1'b0);
      else                               req(1'b0, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if (exp_len == 16) begin
        for (int k = 1; k < 16; k++) begin
          chk("no_repeat", {63'd0, data[63-4*k -: 4] == data[67-4*k -: 4]}, 64'd0);
        end
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
